// File: rtl/apb_master_engine.sv
// APB4 requester engine: turns one READ/WRITE command from the bridge engine into
// a SETUP/ACCESS transfer and reports the result for one APB_SWITCH cycle.
module apb_master_engine #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              apb_cmd,
  output logic [1:0]              apb_info,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    slverr_o,
  output logic                    timeout_o,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] CMD_READ  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;

  localparam logic [1:0] INFO_IDLE   = 2'd0;
  localparam logic [1:0] INFO_BUSY   = 2'd1;
  localparam logic [1:0] INFO_SWITCH = 2'd2;

  logic [1:0]            state_q,   state_d;
  logic [CW-1:0]         cnt_q,     cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic                  write_q,   write_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic                  slverr_q,  slverr_d;
  logic                  timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        // reserved code 3 falls through as DISABLE
        if (apb_cmd == CMD_READ || apb_cmd == CMD_WRITE) begin
          addr_d  = addr_i;
          write_d = (apb_cmd == CMD_WRITE);
          wdata_d = (apb_cmd == CMD_WRITE) ? wdata_i : '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // a late pready on the last allowed cycle still wins over the timeout
        if (pready) begin
          rdata_d   = write_q ? '0 : prdata;
          slverr_d  = pslverr;
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d   = '0;
          slverr_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        timeout_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      timeout_q <= timeout_d;
    end
  end

  // bus controls decode straight from the state flop so reset drops them at once
  always_comb begin
    case (state_q)
      ST_SETUP, ST_ACCESS: apb_info = INFO_BUSY;
      ST_DONE:             apb_info = INFO_SWITCH;
      default:             apb_info = INFO_IDLE;
    endcase
  end

  assign psel      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign penable   = (state_q == ST_ACCESS);
  assign paddr     = addr_q;
  assign pwrite    = write_q;
  assign pwdata    = wdata_q;
  assign pstrb     = {(DATA_WIDTH/8){write_q}};
  assign pprot     = 3'b000;
  assign rdata_o   = rdata_q;
  assign slverr_o  = slverr_q;
  assign timeout_o = timeout_q;

endmodule

// File: doc/apb_master_engine.md
APB_MASTER_ENGINE -- requirements
Module: apb_master_engine

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, maximum ACCESS cycles before forced completion (legal range 2..65536).
REQ-004 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have apb_cmd  input  2  command from bridge engine: 0=APB_DISABLE, 1=APB_READ, 2=APB_WRITE, 3=reserved (treated as DISABLE).
REQ-007 SHALL have apb_info  output  2  status to bridge engine: 0=APB_IDLE, 1=APB_BUSY, 2=APB_SWITCH.
REQ-008 SHALL have addr_i  input  ADDR_WIDTH  transfer address, valid in cycle apb_cmd is non-DISABLE.
REQ-009 SHALL have wdata_i  input  DATA_WIDTH  write data, valid with APB_WRITE.
REQ-010 SHALL have rdata_o  output  DATA_WIDTH  captured read data, valid while apb_info=APB_SWITCH.
REQ-011 SHALL have slverr_o  output  1  transfer error (PSLVERR or timeout), valid while apb_info=APB_SWITCH.
REQ-012 SHALL have timeout_o  output  1  one-cycle pulse, concurrent with APB_SWITCH, when completion was forced by timeout.
REQ-013 SHALL have paddr, psel, penable, pwrite, pwdata, pstrb (DATA_WIDTH/8), pprot (3)  outputs  APB4 requester signals.
REQ-014 SHALL have prdata (DATA_WIDTH), pready (1), pslverr (1)  inputs  APB4 completer response.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-016 IDLE: apb_cmd=APB_READ/APB_WRITE SHALL latch addr_i, wdata_i (write only, else 0), direction; next state SETUP; other codes stay IDLE.
REQ-017 apb_cmd SHALL be ignored in every state except IDLE.
REQ-018 SETUP: psel=1, penable=0, exactly one cycle; next state ACCESS.
REQ-019 ACCESS: psel=1, penable=1; remain until pready=1 or timeout.
REQ-020 paddr, pwrite, pwdata, pstrb, pprot SHALL stay constant from SETUP through last ACCESS cycle.
REQ-021 pstrb SHALL be all-ones for writes, 0 for reads; pprot SHALL be 3'b000.
REQ-022 ACCESS with pready=1: SHALL register rdata_o<=prdata (read) or 0 (write), slverr_o<=pslverr, timeout_o<=0; next DONE.
REQ-023 Timeout counter (ceil(log2(TIMEOUT_CYCLES)) bits) SHALL clear on SETUP->ACCESS and increment each ACCESS cycle with pready=0.
REQ-024 ACCESS with pready=0 and counter=TIMEOUT_CYCLES-1: SHALL register rdata_o<=0, slverr_o<=1, timeout_o<=1; next DONE; psel/penable drop next cycle.
REQ-025 pready=1 on the timeout cycle SHALL take priority: normal completion, timeout_o=0.
REQ-026 DONE: apb_info=APB_SWITCH, psel=0, penable=0, exactly one cycle; next IDLE.
REQ-027 apb_info SHALL be APB_IDLE in IDLE, APB_BUSY in SETUP/ACCESS.
REQ-028 rdata_o, slverr_o SHALL hold their values after DONE until next completion; timeout_o SHALL be 0 outside DONE.
REQ-029 Latency: command in cycle N, zero-wait completer -> SETUP N+1, ACCESS N+2, APB_SWITCH N+3; each wait state adds one cycle.
REQ-030 A new command in the DONE->IDLE cycle boundary SHALL be accepted in IDLE, giving back-to-back transfers with one IDLE cycle between.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, counter 0, and all outputs 0 (apb_info=APB_IDLE, psel=penable=0).
REQ-032 Reset asserted mid-transfer SHALL drop psel/penable immediately without APB_SWITCH; after release, FSM SHALL be in IDLE.

Verification
REQ-033 Write addr_i=0x1000_0040, wdata_i=0xDEAD_BEEF, pready=1 -> psel N+1, penable N+2, pwrite=1, pstrb=0xF, APB_SWITCH at N+3, slverr_o=0.
REQ-034 Read addr_i=0x20, pready low 3 ACCESS cycles then high with prdata=0xCAFE_F00D -> APB_SWITCH at N+6, rdata_o=0xCAFE_F00D.
REQ-035 Read, pready never asserted, TIMEOUT_CYCLES=8 -> 8 ACCESS cycles, APB_SWITCH with slverr_o=1, timeout_o=1, rdata_o=0.
REQ-036 Write with pslverr=1 on pready -> slverr_o=1, timeout_o=0; APB_WRITE pulsed during ACCESS -> ignored, addr unchanged.
REQ-037 rst_n low during ACCESS -> psel=penable=0 same cycle, apb_info=APB_IDLE, no APB_SWITCH; subsequent read completes normally.
